// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter.
// Sends one byte per valid/ready handshake as start(0), 8 data bits LSB first,
// an optional parity bit and one stop bit(1). Every line bit lasts DIV clocks.
// TXD, TX_DONE, TX_READY and BUSY all come straight from flops.
module uart_tx_frame #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TXD,
    output logic       BUSY,
    output logic       TX_DONE
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // A divider below 2 cannot give each line bit its own counter period.
    if (DIV < 2) begin : g_div_check
        $error("uart_tx_frame: CLK_FREQ / BAUD_RATE must be at least 2");
    end

    // Parity bit for a byte: even parity is the XOR of the data, odd inverts it.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          bit_end_s;

    assign bit_end_s = (cnt_q == CNT_MAX);

    // Frame sequencing: handshake, baud counting, bit index and shifting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (TX_VALID) begin
                    shift_d = TX_DATA;
                    if (PARITY_EN != 0) begin
                        par_d = parity_of(TX_DATA, 1'(PARITY_ODD));
                    end else begin
                        par_d = 1'b0;
                    end
                    bit_d   = 3'd0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                bit_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: the line level follows the current state one clock later,
    // so the stop-bit end pulse is timed the same way to line up with TXD.
    always_comb begin
        txd_d   = 1'b1;
        done_d  = 1'b0;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE:   txd_d = 1'b1;
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
            S_PARITY: txd_d = par_q;
            S_STOP: begin
                txd_d  = 1'b1;
                done_d = bit_end_s;
            end
            default:  txd_d = 1'b1;
        endcase
    end

    // State and output registers; reset aborts any frame with the line idle high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign TXD      = txd_q;
    assign TX_DONE  = done_q;
    assign TX_READY = ready_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: five instances with different divider/parity
// settings, a literal vector table, hand-written corner sequences and random
// bytes checked against a frame model built from the line format.
module tb_uart_tx_frame;

    localparam int NI = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    tx_data;
    logic [NI-1:0] tx_valid;
    logic [NI-1:0] tx_ready;
    logic [NI-1:0] txd;
    logic [NI-1:0] busy;
    logic [NI-1:0] tx_done;

    int div_t  [NI] = '{160, 160, 160, 5, 3};
    bit pen_t  [NI] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bit podd_t [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ(1_536_000), .BAUD_RATE(9_600), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
        .CLK(clk), .RST(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid[0]),
        .TX_READY(tx_ready[0]), .TXD(txd[0]), .BUSY(busy[0]), .TX_DONE(tx_done[0]));
    uart_tx_frame #(.CLK_FREQ(1_536_000), .BAUD_RATE(9_600), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .CLK(clk), .RST(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid[1]),
        .TX_READY(tx_ready[1]), .TXD(txd[1]), .BUSY(busy[1]), .TX_DONE(tx_done[1]));
    uart_tx_frame #(.CLK_FREQ(1_536_000), .BAUD_RATE(9_600), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
        .CLK(clk), .RST(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid[2]),
        .TX_READY(tx_ready[2]), .TXD(txd[2]), .BUSY(busy[2]), .TX_DONE(tx_done[2]));
    uart_tx_frame #(.CLK_FREQ(50), .BAUD_RATE(10), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
        .CLK(clk), .RST(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid[3]),
        .TX_READY(tx_ready[3]), .TXD(txd[3]), .BUSY(busy[3]), .TX_DONE(tx_done[3]));
    uart_tx_frame #(.CLK_FREQ(7), .BAUD_RATE(2), .PARITY_EN(0), .PARITY_ODD(0)) u4 (
        .CLK(clk), .RST(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid[4]),
        .TX_READY(tx_ready[4]), .TXD(txd[4]), .BUSY(busy[4]), .TX_DONE(tx_done[4]));

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [10:0] exp;   // exp[i] = i-th bit on the line, start bit first
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line bits from the frame format: start 0, data LSB first,
    // parity chosen so the number of ones matches even/odd, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b, input bit pen, input bit podd);
        logic [10:0] f;
        int ones;
        ones = 0;
        f    = 11'h7FF;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k + 1] = b[k];
            ones     = ones + int'(b[k]);
        end
        if (pen) begin
            f[9] = ((ones % 2) == 1) ? ~podd : podd;
        end else begin
            f[9] = 1'b1;
        end
        f[10] = 1'b1;
        return f;
    endfunction

    // Called at a negedge: present the byte, check the accept edge, drop valid
    // unless told to hold it. Returns at the negedge of the first start-bit clock.
    task automatic send(input int inst, input logic [7:0] data, input bit hold, input string tag);
        tx_data        = data;
        tx_valid[inst] = 1'b1;
        @(negedge clk);
        check({tag, " accept ready"}, 32'(tx_ready[inst]), 32'd0);
        check({tag, " accept busy"}, 32'(busy[inst]), 32'd1);
        check({tag, " latency txd"}, 32'(txd[inst]), 32'd1);
        if (!hold) begin
            tx_valid[inst] = 1'b0;
        end
        @(negedge clk);
    endtask

    // Starting at the negedge of the first start-bit clock, check every clock
    // of the frame. Returns at the negedge of the last stop-bit clock.
    task automatic check_frame(input int inst, input logic [10:0] exp, input string tag);
        int nb;
        int dv;
        int ndone;
        int bad_done;
        int bad_cmp;
        int nwrong;
        nb       = pen_t[inst] ? 11 : 10;
        dv       = div_t[inst];
        ndone    = 0;
        bad_done = 0;
        bad_cmp  = 0;
        for (int b = 0; b < nb; b++) begin
            nwrong = 0;
            for (int c = 0; c < dv; c++) begin
                if (b != 0 || c != 0) begin
                    @(negedge clk);
                end
                if (txd[inst] !== exp[b]) nwrong++;
                if (tx_done[inst] === 1'b1) ndone++;
                if (tx_done[inst] !== ((b == nb - 1) && (c == dv - 1))) bad_done++;
                if (busy[inst] === tx_ready[inst]) bad_cmp++;
            end
            check($sformatf("%s bit%0d wrong clocks", tag, b), 32'(nwrong), 32'd0);
        end
        check({tag, " done count"}, 32'(ndone), 32'd1);
        check({tag, " done position"}, 32'(bad_done), 32'd0);
        check({tag, " busy/ready"}, 32'(bad_cmp), 32'd0);
    endtask

    // Two frames with valid held high across the first stop bit.
    task automatic b2b(input int inst, input logic [10:0] e1, input logic [10:0] e2, input string tag);
        send(inst, 8'h4F, 1'b1, {tag, " f1"});
        tx_data = 8'h00;
        check_frame(inst, e1, {tag, " f1"});
        @(negedge clk);
        check({tag, " gap txd"}, 32'(txd[inst]), 32'd1);
        check({tag, " gap ready"}, 32'(tx_ready[inst]), 32'd0);
        tx_valid[inst] = 1'b0;
        @(negedge clk);
        check_frame(inst, e2, {tag, " f2"});
        @(negedge clk);
    endtask

    initial begin
        int bad;
        logic [7:0] rb;

        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = '0;

        tbl[0] = '{0, 8'h41, 11'b1_0_01000001_0};
        tbl[1] = '{2, 8'hA5, 11'b0_1_10100101_0};
        tbl[2] = '{0, 8'hFF, 11'b1_0_11111111_0};
        tbl[3] = '{1, 8'h41, 11'b1_1_01000001_0};
        tbl[4] = '{3, 8'h80, 11'b1_0_10000000_0};
        tbl[5] = '{4, 8'h01, 11'b0_1_00000001_0};

        // Reset and idle
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (txd !== 5'h1F || tx_ready !== 5'h1F || busy !== 5'h00 || tx_done !== 5'h00) bad++;
        end
        check("reset outputs", 32'(bad), 32'd0);
        rst_n = 1'b1;
        bad   = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 5'h1F || tx_ready !== 5'h1F || busy !== 5'h00 || tx_done !== 5'h00) bad++;
        end
        check("idle outputs", 32'(bad), 32'd0);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].inst, tbl[i].data, 1'b0, $sformatf("vec%0d", i));
            check_frame(tbl[i].inst, tbl[i].exp, $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Back-to-back, even then odd parity
        b2b(0, 11'b1_1_01001111_0, 11'b1_0_00000000_0, "b2b even");
        b2b(1, 11'b1_0_01001111_0, 11'b1_1_00000000_0, "b2b odd");

        // No parity, data changed mid-frame
        send(2, 8'hA5, 1'b0, "nopar");
        fork
            check_frame(2, 11'b0_1_10100101_0, "nopar");
            begin
                repeat (700) @(negedge clk);
                tx_data = 8'hFF;
            end
        join
        repeat (3) @(negedge clk);

        // Reset during Data[3]
        send(0, 8'h41, 1'b0, "rst mid");
        repeat (4 * 160 + 80) @(negedge clk);
        check("rst mid pre txd", 32'(txd[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid txd", 32'(txd[0]), 32'd1);
        check("rst mid ready", 32'(tx_ready[0]), 32'd1);
        check("rst mid busy", 32'(busy[0]), 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_done[0] !== 1'b0 || txd[0] !== 1'b1) bad++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (tx_done[0] !== 1'b0 || txd[0] !== 1'b1) bad++;
        end
        check("rst mid no done", 32'(bad), 32'd0);
        send(0, 8'h41, 1'b0, "after rst");
        check_frame(0, 11'b1_0_01000001_0, "after rst");
        repeat (3) @(negedge clk);

        // Valid pulsed while busy is ignored
        send(0, 8'h41, 1'b0, "ignore");
        fork
            check_frame(0, 11'b1_0_01000001_0, "ignore");
            begin
                repeat (300) @(negedge clk);
                tx_data     = 8'h55;
                tx_valid[0] = 1'b1;
                @(negedge clk);
                tx_valid[0] = 1'b0;
            end
        join
        bad = 0;
        repeat (320) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || tx_done[0] !== 1'b0 || tx_ready[0] !== 1'b1) bad++;
        end
        check("ignore stays idle", 32'(bad), 32'd0);

        // Random bytes on the short-divider instances
        for (int n = 0; n < 40; n++) begin
            int inst;
            inst = (n % 2 == 0) ? 3 : 4;
            rb   = 8'($urandom_range(0, 255));
            send(inst, rb, 1'b0, $sformatf("rnd%0d", n));
            check_frame(inst, model_frame(rb, pen_t[inst], podd_t[inst]), $sformatf("rnd%0d %02h", n, rb));
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
